mdio_master: RTL
================

// Module: mdio_master
// PURPOSE
//  Clause-22 MDIO management master. Sequences single PHY register read/write frames
//  from a command/response handshake. Generates MDC by dividing clk_i, drives the
//  shared MDIO line, and captures read data. Sits between the MAC MDIC CSR logic and
//  the PHY-side MDIO pins, or the on-chip PHY register emulator.
// PARAMETERS
//  CLK_DIV       16  clk_i cycles per MDC half-period; legal range 4..255
//  PREAMBLE_LEN  32  preamble '1' bits before ST; 0 = preamble suppression
// PORTS
//  clk_i      in   1   system clock
//  rst_i      in   1   reset, asynchronous, active-high
//  cmd_valid  in   1   command request
//  cmd_ready  out  1   block can accept a command (==!busy)
//  cmd_op     in   1   1=read, 0=write
//  cmd_phy    in   5   PHY address
//  cmd_reg    in   5   register address
//  cmd_wdata  in   16  write data (ignored for read)
//  rsp_valid  out  1   one-cycle pulse: transaction complete
//  rsp_rdata  out  16  read data, valid with rsp_valid; 0 for writes
//  busy       out  1   transaction in progress
//  mdc_o      out  1   management clock
//  mdio_o     out  1   MDIO output value
//  mdio_oe    out  1   MDIO output enable (1 = master drives)
//  mdio_i     in   1   MDIO input (asynchronous; 2-flop synchronised internally)
// BEHAVIOUR
//  Reset values: mdc_o=0, mdio_o=1, mdio_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0.
//  Handshake: accept when cmd_valid&&cmd_ready; latch op/phy/reg/wdata; busy=1 and cmd_ready=0 next cycle.
//  A cmd_valid held while busy is not accepted.
//  Bit period: 2*CLK_DIV cycles, MDC low phase first, then high. Divider runs only while busy.
//  mdc_o is held 0 while idle.
//  Master updates mdio_o/mdio_oe on the first cycle of each low phase.
//  Master samples synchronised mdio_i on the last cycle of the low phase, just before MDC rises.
//  Frame: PREAMBLE_LEN x '1', ST=01, OP (read 10 / write 01), PHY[4:0], REG[4:0] MSB first.
//  Then TA + 16 data bits.
//  Write: TA=10 driven; data = cmd_wdata[15:15..0]; mdio_oe=1 for the whole frame.
//  Read: mdio_oe=0 from the first TA bit through data bit 0.
//  Read data = 16 bits sampled in data periods 1..16, MSB first. TA bits are not checked.
//  FSM: IDLE -> PRE (skipped if PREAMBLE_LEN==0) -> HDR (14 bits) -> TA (2) -> DATA (16) -> DONE -> IDLE.
//   - Bit counter advances at the end of each high phase.
//   - DONE lasts one cycle: mdio_oe=0, mdio_o=1, mdc_o=0, rsp_valid=1, busy=0, cmd_ready=1.
//   - A new command may be accepted in the DONE cycle.
//  Latency: accept cycle to rsp_valid = 1 + (PREAMBLE_LEN+32)*2*CLK_DIV cycles.
//  rsp_rdata holds its value until the next rsp_valid.
//  Reset mid-transaction: immediate abort to reset values; no rsp_valid is issued.
//  Divider counter width is 8 bits; bit counter is 6 bits (max 64 preamble bits).
// STRUCTURE
//  Shared package mdio_pkg:
//   - MDIO_ST=2'b01, MDIO_OP_RD=2'b10, MDIO_OP_WR=2'b01, MDIO_TA_WR=2'b10
//   - FSM state encodings, shared with the slave emulator bench models
//  Sub-module mdio_clkgen: CLK_DIV divider with enable.
//   - Outputs mdc_o, fall_stb (first low cycle), samp_stb (last low cycle), rise_end_stb (last high cycle).
//   - Top level holds the FSM, shift register and synchroniser.
// TESTING (behavioural clause-22 PHY model, CLK_DIV=4 unless stated)
//  1 Write phy=1 reg=0x04 wdata=0x01E1 -> 64 bit periods on the line.
//    Model decodes ST=01 OP=01 PA=1 RA=4 TA=10 D=0x01E1.
//    rsp_valid exactly 1+64*8=513 cycles after accept; rsp_rdata=0.
//  2 Read phy=0 reg=0x02, model returns 0x0141 -> mdio_oe drops at the first TA bit.
//    rsp_rdata=0x0141 with rsp_valid.
//  3 PREAMBLE_LEN=0, read reg=0x01, model data 0x796D -> no preamble bits on the line.
//    rsp_rdata=0x796D at 1+32*8=257 cycles.
//  4 Back-to-back: cmd_valid held high with two writes -> second accepted in the DONE cycle.
//    mdc_o stays low for exactly 1 cycle between frames.
//  5 cmd_valid pulsed while busy -> ignored; only one frame observed.
//  6 rst_i asserted mid-DATA of a read -> outputs at reset values asynchronously; no rsp_valid.
//    Next command completes normally.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared Clause-22 MDIO definitions: frame field codes, FSM state encoding and frame builder.
package mdio_pkg;

   localparam logic [1:0] MDIO_ST    = 2'b01;
   localparam logic [1:0] MDIO_OP_RD = 2'b10;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;
   localparam logic [1:0] MDIO_TA_WR = 2'b10;
   // Read TA and data slots are never driven; a released line idles high.
   localparam logic [1:0] MDIO_TA_RD = 2'b11;

   localparam logic [5:0] HDR_TC  = 6'd13;
   localparam logic [5:0] TA_TC   = 6'd1;
   localparam logic [5:0] DATA_TC = 6'd15;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_HDR  = 3'd2,
      ST_TA   = 3'd3,
      ST_DATA = 3'd4,
      ST_DONE = 3'd5
   } mdio_state_e;

   function automatic logic [31:0] mdio_frame(input logic        rd,
                                              input logic [4:0]  phy,
                                              input logic [4:0]  reg_addr,
                                              input logic [15:0] wdata);
      logic [1:0]  op;
      logic [1:0]  ta;
      logic [15:0] data;
      op   = rd ? MDIO_OP_RD : MDIO_OP_WR;
      ta   = rd ? MDIO_TA_RD : MDIO_TA_WR;
      data = rd ? 16'hFFFF : wdata;
      return {MDIO_ST, op, phy, reg_addr, ta, data};
   endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: low half-period then high half-period, CLK_DIV cycles each, with phase strobes.
module mdio_clkgen
   import mdio_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic mdc_o,
   output logic fall_stb,
   output logic samp_stb,
   output logic rise_end_stb
);

   localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

   logic [7:0] div_cnt_q, div_cnt_d;
   logic       phase_q, phase_d;

   // Disabled: parked at the start of a low phase so the next frame begins cleanly.
   always_comb begin
      div_cnt_d = div_cnt_q;
      phase_d   = phase_q;
      if (!en_i) begin
         div_cnt_d = DIV_TC;
         phase_d   = 1'b0;
      end else if (div_cnt_q == 8'd0) begin
         div_cnt_d = DIV_TC;
         phase_d   = ~phase_q;
      end else begin
         div_cnt_d = div_cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_cnt_q <= DIV_TC;
         phase_q   <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         phase_q   <= phase_d;
      end
   end

   assign mdc_o        = phase_q;
   assign fall_stb     = en_i && !phase_q && (div_cnt_q == DIV_TC);
   assign samp_stb     = en_i && !phase_q && (div_cnt_q == 8'd0);
   assign rise_end_stb = en_i &&  phase_q && (div_cnt_q == 8'd0);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one read/write frame per accepted command, response pulse on completion.
//
//  state   | meaning
//  IDLE    | line released, waiting for a command
//  PRE     | driving preamble '1' bits
//  HDR     | ST, OP, PHY, REG (14 bits)
//  TA      | turnaround: driven 10 on writes, released on reads
//  DATA    | 16 data bits, driven (write) or sampled (read)
//  DONE    | single-cycle response; may accept the next command
module mdio_master
   import mdio_pkg::*;
#(
   parameter int CLK_DIV      = 16,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [4:0]  cmd_phy,
   input  logic [4:0]  cmd_reg,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        busy,
   output logic        mdc_o,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);

   localparam logic [5:0] PRE_TC = 6'(PREAMBLE_LEN - 1);

   mdio_state_e state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] frm_q, frm_d;
   logic        rd_q, rd_d;
   logic [15:0] rd_sh_q, rd_sh_d;
   logic [15:0] rdata_q, rdata_d;
   logic        mdio_o_q, mdio_o_d;
   logic        mdio_oe_q, mdio_oe_d;
   logic [1:0]  sync_q, sync_d;

   logic [31:0] frame_w;
   logic        fall_stb, samp_stb, rise_end_stb;

   assign busy      = (state_q == ST_PRE) || (state_q == ST_HDR) ||
                      (state_q == ST_TA)  || (state_q == ST_DATA);
   assign cmd_ready = !busy;
   assign rsp_valid = (state_q == ST_DONE);
   assign rsp_rdata = rdata_q;
   assign mdio_o    = mdio_o_q;
   assign mdio_oe   = mdio_oe_q;
   assign frame_w   = mdio_frame(cmd_op, cmd_phy, cmd_reg, cmd_wdata);

   mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_i         (busy),
      .mdc_o        (mdc_o),
      .fall_stb     (fall_stb),
      .samp_stb     (samp_stb),
      .rise_end_stb (rise_end_stb)
   );

   // Next line value is loaded at the end of each high phase, so it appears on the
   // first cycle of the following low phase.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      frm_d     = frm_q;
      rd_d      = rd_q;
      rd_sh_d   = rd_sh_q;
      rdata_d   = rdata_q;
      mdio_o_d  = mdio_o_q;
      mdio_oe_d = mdio_oe_q;
      sync_d    = {sync_q[0], mdio_i};

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d   = ST_IDLE;
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
            if (cmd_valid) begin
               rd_d      = cmd_op;
               mdio_oe_d = 1'b1;
               if (PREAMBLE_LEN > 0) begin
                  state_d   = ST_PRE;
                  bit_cnt_d = PRE_TC;
                  frm_d     = frame_w;
               end else begin
                  state_d   = ST_HDR;
                  bit_cnt_d = HDR_TC;
                  mdio_o_d  = frame_w[31];
                  frm_d     = {frame_w[30:0], 1'b0};
               end
            end
         end
         ST_PRE: begin
            if (rise_end_stb) begin
               if (bit_cnt_q == 6'd0) begin
                  state_d   = ST_HDR;
                  bit_cnt_d = HDR_TC;
                  mdio_o_d  = frm_q[31];
                  frm_d     = {frm_q[30:0], 1'b0};
               end else begin
                  bit_cnt_d = bit_cnt_q - 6'd1;
               end
            end
         end
         ST_HDR: begin
            if (rise_end_stb) begin
               mdio_o_d = frm_q[31];
               frm_d    = {frm_q[30:0], 1'b0};
               if (bit_cnt_q == 6'd0) begin
                  state_d   = ST_TA;
                  bit_cnt_d = TA_TC;
                  mdio_oe_d = !rd_q;
               end else begin
                  bit_cnt_d = bit_cnt_q - 6'd1;
               end
            end
         end
         ST_TA: begin
            if (rise_end_stb) begin
               mdio_o_d = frm_q[31];
               frm_d    = {frm_q[30:0], 1'b0};
               if (bit_cnt_q == 6'd0) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = DATA_TC;
               end else begin
                  bit_cnt_d = bit_cnt_q - 6'd1;
               end
            end
         end
         ST_DATA: begin
            if (samp_stb) begin
               rd_sh_d = {rd_sh_q[14:0], sync_q[1]};
            end
            if (rise_end_stb) begin
               if (bit_cnt_q == 6'd0) begin
                  state_d   = ST_DONE;
                  mdio_o_d  = 1'b1;
                  mdio_oe_d = 1'b0;
                  rdata_d   = rd_q ? rd_sh_q : 16'h0000;
               end else begin
                  bit_cnt_d = bit_cnt_q - 6'd1;
                  mdio_o_d  = frm_q[31];
                  frm_d     = {frm_q[30:0], 1'b0};
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 6'd0;
         frm_q     <= 32'h0;
         rd_q      <= 1'b0;
         rd_sh_q   <= 16'h0;
         rdata_q   <= 16'h0;
         mdio_o_q  <= 1'b1;
         mdio_oe_q <= 1'b0;
         sync_q    <= 2'b11;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         frm_q     <= frm_d;
         rd_q      <= rd_d;
         rd_sh_q   <= rd_sh_d;
         rdata_q   <= rdata_d;
         mdio_o_q  <= mdio_o_d;
         mdio_oe_q <= mdio_oe_d;
         sync_q    <= sync_d;
      end
   end

   // The line must only move on the first cycle of a low phase.
   a_line_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (busy && !fall_stb) |-> ($stable(mdio_o_q) && $stable(mdio_oe_q)));

endmodule
